// File: rtl/alu_16_sched.sv
// Round-robin scheduler sharing one combinational 16-bit ALU among NUM_REQ requesters.
// Operands are registered, held for SETTLE_CYCLES, then the ALU result is captured and returned.
module alu_16_sched #(
   parameter int unsigned NUM_REQ       = 4,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned ID_W          = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*16-1:0]  req_a,
   input  logic [NUM_REQ*16-1:0]  req_b,
   input  logic [NUM_REQ-1:0]     req_mode,
   input  logic [NUM_REQ*4-1:0]   req_sel,
   input  logic [NUM_REQ-1:0]     req_cin,
   output logic [15:0]            alu_a,
   output logic [15:0]            alu_b,
   output logic                   alu_mode,
   output logic [3:0]             alu_sel,
   output logic                   alu_cin,
   input  logic [15:0]            alu_result,
   input  logic                   alu_cout,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [15:0]            rsp_result,
   output logic                   rsp_cout,
   output logic                   busy
);

   localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int unsigned SumW = ID_W + 1;

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [ID_W-1:0]   id_q;
   logic [15:0]       a_q, b_q, res_q;
   logic              mode_q, cin_q, cout_q;
   logic [3:0]        sel_q;

   logic              found;
   logic [ID_W-1:0]   win;
   logic [SumW-1:0]   scan_sum;
   logic [ID_W-1:0]   scan_idx;
   logic [15:0]       win_a, win_b;
   logic              win_mode, win_cin;
   logic [3:0]        win_sel;
   logic              load, capture;

   // First valid requester at or after ptr, wrapping modulo NUM_REQ.
   always_comb begin
      found    = 1'b0;
      win      = '0;
      scan_sum = '0;
      scan_idx = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         scan_sum = SumW'(ptr_q) + SumW'(k);
         if (scan_sum >= SumW'(NUM_REQ)) begin
            scan_sum = scan_sum - SumW'(NUM_REQ);
         end
         scan_idx = scan_sum[ID_W-1:0];
         if (!found && req_valid[scan_idx]) begin
            found = 1'b1;
            win   = scan_idx;
         end
      end
   end

   always_comb begin
      win_a    = '0;
      win_b    = '0;
      win_mode = 1'b0;
      win_sel  = '0;
      win_cin  = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (win == ID_W'(i)) begin
            win_a    = req_a[16*i +: 16];
            win_b    = req_b[16*i +: 16];
            win_mode = req_mode[i];
            win_sel  = req_sel[4*i +: 4];
            win_cin  = req_cin[i];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      load      = 1'b0;
      capture   = 1'b0;
      req_ready = '0;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               req_ready[win] = 1'b1;
               load           = 1'b1;
               cnt_d          = CntW'(SETTLE_CYCLES - 1);
               state_d        = StExec;
            end
         end
         StExec: begin
            if (cnt_q == '0) begin
               capture = 1'b1;
               state_d = StResp;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StResp: begin
            // Pointer advances only on completion so a stalled response keeps fairness intact.
            if (rsp_ready) begin
               ptr_d   = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         cnt_q   <= '0;
         id_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         mode_q  <= 1'b0;
         sel_q   <= '0;
         cin_q   <= 1'b0;
         res_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         if (load) begin
            id_q   <= win;
            a_q    <= win_a;
            b_q    <= win_b;
            mode_q <= win_mode;
            sel_q  <= win_sel;
            cin_q  <= win_cin;
         end
         if (capture) begin
            res_q  <= alu_result;
            cout_q <= alu_cout;
         end
      end
   end

   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_mode   = mode_q;
   assign alu_sel    = sel_q;
   assign alu_cin    = cin_q;
   assign rsp_valid  = (state_q == StResp);
   assign rsp_id     = id_q;
   assign rsp_result = res_q;
   assign rsp_cout   = cout_q;
   assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_alu_16_sched.sv
// Bench for alu_16_sched: directed vectors, scheduling corner cases and a randomized scoreboard run.
// A behavioural 74181-style ALU sits on the alu_* port pair.
module tb_alu_16_sched;

   localparam int N = 4;
   localparam int S = 2;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [N-1:0]      req_valid = '0;
   logic [N-1:0]      req_ready;
   logic [N*16-1:0]   req_a = '0;
   logic [N*16-1:0]   req_b = '0;
   logic [N-1:0]      req_mode = '0;
   logic [N*4-1:0]    req_sel = '0;
   logic [N-1:0]      req_cin = '0;
   logic [15:0]       alu_a, alu_b, alu_result;
   logic              alu_mode, alu_cin, alu_cout;
   logic [3:0]        alu_sel;
   logic              rsp_valid;
   logic              rsp_ready = 1'b1;
   logic [1:0]        rsp_id;
   logic [15:0]       rsp_result;
   logic              rsp_cout;
   logic              busy;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   alu_16_sched #(.NUM_REQ(N), .SETTLE_CYCLES(S), .ID_W(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_mode(req_mode), .req_sel(req_sel), .req_cin(req_cin),
      .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_sel(alu_sel), .alu_cin(alu_cin),
      .alu_result(alu_result), .alu_cout(alu_cout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_cout(rsp_cout), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // 74181 with active-high data: F = X plus Y plus carry (arith), F = ~X ^ Y (logic); Cn/Cn+4 active-low.
   function automatic logic [16:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                          input logic m, input logic [3:0] s, input logic cin);
      logic [15:0] x, y;
      logic [16:0] sum;
      x = a | (s[0] ? b : 16'h0) | (s[1] ? ~b : 16'h0);
      y = (s[2] ? (a & ~b) : 16'h0) | (s[3] ? (a & b) : 16'h0);
      if (m) return {1'b1, ~x ^ y};
      sum = {1'b0, x} + {1'b0, y} + {16'h0, ~cin};
      return {~sum[16], sum[15:0]};
   endfunction

   always_comb {alu_cout, alu_result} = alu_fn(alu_a, alu_b, alu_mode, alu_sel, alu_cin);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic m, input logic [3:0] s, input logic c);
      req_a[16*i +: 16] = a;
      req_b[16*i +: 16] = b;
      req_mode[i]       = m;
      req_sel[4*i +: 4] = s;
      req_cin[i]        = c;
   endtask

   task automatic do_reset;
      req_valid = '0;
      rsp_ready = 1'b1;
      #2 reset_n = 1'b0;
      @(negedge clk);
      check("rst_ready", 64'(req_ready), 64'h0);
      check("rst_alu", 64'({alu_a, alu_b, alu_mode, alu_sel, alu_cin}), 64'h0);
      check("rst_rsp", 64'({rsp_valid, rsp_id, rsp_result, rsp_cout, busy}), 64'h0);
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic wait_grant(output int gid, output int gcyc);
      bit seen;
      seen = 1'b0;
      gid  = -1;
      gcyc = -1;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (req_ready != '0) begin
            seen = 1'b1;
            gcyc = cyc;
            for (int j = 0; j < N; j++) if (req_ready[j]) gid = j;
         end
      end
      check("grant_seen", 64'(seen), 64'h1);
   endtask

   task automatic wait_rsp(output int rc);
      bit seen;
      seen = 1'b0;
      rc   = -1;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (rsp_valid) begin
            seen = 1'b1;
            rc   = cyc;
         end
      end
      check("rsp_seen", 64'(seen), 64'h1);
   endtask

   typedef struct {
      int          id;
      logic [15:0] a, b;
      logic        m;
      logic [3:0]  s;
      logic        c;
      logic [15:0] er;
      logic        ec;
   } vec_t;

   vec_t vt[7];

   initial begin
      int g, gid, rc, prev;
      int exp_order[5];
      logic [N-1:0] exp_ready, gnt_clear;
      int mptr;
      bit mbusy;
      logic [1:0] exp_id;
      logic [16:0] exp_rc;
      int exp_cyc;

      vt[0] = '{0, 16'h0005, 16'h0003, 1'b0, 4'b1001, 1'b1, 16'h0008, 1'b1};
      vt[1] = '{1, 16'hFFFF, 16'h0001, 1'b0, 4'b1001, 1'b1, 16'h0000, 1'b0};
      vt[2] = '{2, 16'h1234, 16'h00FF, 1'b1, 4'b1011, 1'b1, 16'h0034, 1'b1};
      vt[3] = '{3, 16'h00F0, 16'h0F0F, 1'b1, 4'b0110, 1'b0, 16'h0FFF, 1'b1};
      vt[4] = '{0, 16'h0010, 16'h0001, 1'b0, 4'b0110, 1'b1, 16'h000E, 1'b0};
      vt[5] = '{1, 16'h0010, 16'h0001, 1'b0, 4'b0110, 1'b0, 16'h000F, 1'b0};
      vt[6] = '{2, 16'h8000, 16'h8000, 1'b0, 4'b1100, 1'b0, 16'h0001, 1'b0};

      do_reset();

      // Directed vectors, one requester at a time.
      foreach (vt[v]) begin
         @(posedge clk);
         #1;
         set_op(vt[v].id, vt[v].a, vt[v].b, vt[v].m, vt[v].s, vt[v].c);
         req_valid[vt[v].id] = 1'b1;
         wait_grant(gid, g);
         check("vec_gid", 64'(gid), 64'(vt[v].id));
         @(posedge clk);
         #1 req_valid = '0;
         check("vec_alu_in", 64'({alu_a, alu_b, alu_mode, alu_sel, alu_cin}),
               64'({vt[v].a, vt[v].b, vt[v].m, vt[v].s, vt[v].c}));
         wait_rsp(rc);
         check("vec_latency", 64'(rc - g), 64'(1 + S));
         check("vec_rsp", 64'({rsp_id, rsp_result, rsp_cout}),
               64'({2'(vt[v].id), vt[v].er, vt[v].ec}));
      end

      // All requesters valid: strict rotation, SETTLE+2 cycles apart.
      do_reset();
      exp_order = '{0, 1, 2, 3, 0};
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) set_op(i, 16'(i * 3), 16'(i), 1'b0, 4'b1001, 1'b1);
      req_valid = '1;
      prev = 0;
      for (int i = 0; i < 5; i++) begin
         wait_grant(gid, g);
         check("rr_order", 64'(gid), 64'(exp_order[i]));
         if (i > 0) check("rr_spacing", 64'(g - prev), 64'(S + 2));
         prev = g;
      end
      @(posedge clk);
      #1 req_valid = '0;

      // Sparse requests: 2, then 1+3 -> 3, 1.
      do_reset();
      @(posedge clk);
      #1 req_valid = 4'b0100;
      wait_grant(gid, g);
      check("sparse_g0", 64'(gid), 64'd2);
      @(posedge clk);
      #1 req_valid = 4'b1010;
      wait_grant(gid, g);
      check("sparse_g1", 64'(gid), 64'd3);
      @(posedge clk);
      #1 req_valid = 4'b0010;
      wait_grant(gid, g);
      check("sparse_g2", 64'(gid), 64'd1);
      @(posedge clk);
      #1 req_valid = '0;

      // Response backpressure.
      do_reset();
      rsp_ready = 1'b0;
      @(posedge clk);
      #1;
      set_op(0, 16'h0005, 16'h0003, 1'b0, 4'b1001, 1'b1);
      req_valid = 4'b0011;
      wait_grant(gid, g);
      check("bp_gid", 64'(gid), 64'd0);
      @(posedge clk);
      #1 req_valid = 4'b0010;
      wait_rsp(rc);
      for (int j = 0; j < 5; j++) begin
         check("bp_hold_rsp", 64'({rsp_valid, rsp_id, rsp_result, rsp_cout}),
               64'({1'b1, 2'd0, 16'h0008, 1'b1}));
         check("bp_no_grant", 64'(req_ready), 64'h0);
         if (j < 4) @(negedge clk);
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_last_rsp", 64'({rsp_valid, req_ready}), 64'({1'b1, 4'b0000}));
      wait_grant(gid, g);
      check("bp_next_gid", 64'(gid), 64'd1);
      check("bp_next_cyc", 64'(g - rc), 64'd6);
      check("bp_rsp_done", 64'(rsp_valid), 64'h0);
      @(posedge clk);
      #1 req_valid = '0;

      // Reset during EXEC drops the op and clears the pointer.
      do_reset();
      @(posedge clk);
      #1 req_valid = 4'b0010;
      wait_grant(gid, g);
      @(posedge clk);
      #1 req_valid = '0;
      wait_rsp(rc);
      @(posedge clk);
      #1 req_valid = 4'b0100;
      wait_grant(gid, g);
      check("mid_gid", 64'(gid), 64'd2);
      @(posedge clk);
      #1 req_valid = '0;
      check("mid_busy_pre", 64'(busy), 64'h1);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_out", 64'({rsp_valid, busy, alu_a}), 64'h0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      prev = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (rsp_valid) prev = 1;
      end
      check("mid_no_rsp", 64'(prev), 64'h0);
      @(posedge clk);
      #1 req_valid = '1;
      wait_grant(gid, g);
      check("mid_next_gid", 64'(gid), 64'd0);
      @(posedge clk);
      #1 req_valid = '0;

      // Randomized run against a transaction-level scoreboard.
      do_reset();
      mptr      = 0;
      mbusy     = 1'b0;
      exp_id    = '0;
      exp_rc    = '0;
      exp_cyc   = 0;
      gnt_clear = '0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         exp_ready = '0;
         if (!mbusy) begin
            for (int k = 0; k < N; k++) begin
               int idx;
               idx = (mptr + k) % N;
               if (req_valid[idx] && exp_ready == '0) exp_ready[idx] = 1'b1;
            end
         end
         check("rnd_ready", 64'(req_ready), 64'(exp_ready));
         check("rnd_busy", 64'(busy), 64'(mbusy));
         check("rnd_rsp_valid", 64'(rsp_valid), 64'(mbusy && cyc >= exp_cyc));
         if (rsp_valid && mbusy && cyc >= exp_cyc) begin
            check("rnd_rsp", 64'({rsp_id, rsp_result, rsp_cout}),
                  64'({exp_id, exp_rc[15:0], exp_rc[16]}));
            if (rsp_ready) begin
               mptr  = (int'(exp_id) + 1) % N;
               mbusy = 1'b0;
            end
         end
         if (exp_ready != '0) begin
            for (int i = 0; i < N; i++) begin
               if (exp_ready[i]) begin
                  exp_id = 2'(i);
                  exp_rc = alu_fn(req_a[16*i +: 16], req_b[16*i +: 16], req_mode[i],
                                  req_sel[4*i +: 4], req_cin[i]);
               end
            end
            mbusy     = 1'b1;
            exp_cyc   = cyc + 1 + S;
            gnt_clear = exp_ready;
         end
         @(posedge clk);
         #1;
         req_valid = req_valid & ~gnt_clear;
         gnt_clear = '0;
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && ($urandom % 4) == 0) begin
               set_op(i, 16'($urandom), 16'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
               req_valid[i] = 1'b1;
            end else if (req_valid[i] && ($urandom % 16) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         rsp_ready = ($urandom % 4) != 0;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
